// File: rtl/cond_pkg.sv
// Shared definitions for the condition / IT-block unit: condition codes,
// opcode constants and NZCV bit positions.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam logic [7:0] IT_OPCODE     = 8'hBF;
    localparam logic [3:0] BRANCH_OPCODE = 4'b1101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code evaluation against an NZCV vector.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n_bit;
    logic z_bit;
    logic c_bit;
    logic v_bit;

    assign n_bit = nzcv[FLAG_N];
    assign z_bit = nzcv[FLAG_Z];
    assign c_bit = nzcv[FLAG_C];
    assign v_bit = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_bit;
            COND_NE: pass = ~z_bit;
            COND_CS: pass = c_bit;
            COND_CC: pass = ~c_bit;
            COND_MI: pass = n_bit;
            COND_PL: pass = ~n_bit;
            COND_VS: pass = v_bit;
            COND_VC: pass = ~v_bit;
            COND_HI: pass = c_bit & ~z_bit;
            COND_LS: pass = ~c_bit | z_bit;
            COND_GE: pass = (n_bit == v_bit);
            COND_LT: pass = (n_bit != v_bit);
            COND_GT: pass = ~z_bit & (n_bit == v_bit);
            COND_LE: pass = z_bit | (n_bit != v_bit);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_it_unit.sv
// Condition evaluation with NZCV flag register and optional Thumb IT-block
// tracking (enabled by defining COND_IT_EN).
module cond_it_unit
    import cond_pkg::*;
#(
    parameter int         IR_W      = 16,
    parameter int         COND_LSB  = 8,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IR_W-1:0] IR,
    input  logic            IR_VALID,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            FLAG_WE,
    input  logic [3:0]      FLAG_IN,
    output logic [3:0]      FLAGS,
    output logic            COND_TRUE,
    output logic            EXEC,
    output logic            IT_ACTIVE,
    output logic [3:0]      IT_COND
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       it_active;
    logic [3:0] it_cond_int;
    logic [3:0] cond_sel;
    logic       cond_pass;

    // Flag writes are independent of stall/flush; new flags are seen next cycle.
    always_comb begin
        flags_d = flags_q;
        if (FLAG_WE) begin
            flags_d = FLAG_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_IT_EN
    logic [7:0] itstate_q;
    logic [7:0] itstate_d;
    logic       accept;

    assign accept      = IR_VALID & ~STALL;
    assign it_active   = (itstate_q[3:0] != 4'h0);
    assign it_cond_int = it_active ? itstate_q[7:4] : COND_AL;

    // An IT opcode seen inside a block is just another slot, never a reload.
    always_comb begin
        itstate_d = itstate_q;
        if (FLUSH) begin
            itstate_d = 8'h00;
        end else if (accept) begin
            if (it_active) begin
                if (itstate_q[2:0] == 3'b000) begin
                    itstate_d = 8'h00;
                end else begin
                    itstate_d[4:0] = {itstate_q[3:0], 1'b0};
                end
            end else if ((IR[15:8] == IT_OPCODE) && (IR[3:0] != 4'h0)) begin
                itstate_d = IR[7:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            itstate_q <= 8'h00;
        end else begin
            itstate_q <= itstate_d;
        end
    end
`else
    assign it_active   = 1'b0;
    assign it_cond_int = COND_AL;
`endif

    always_comb begin
        cond_sel = COND_AL;
        if (it_active) begin
            cond_sel = it_cond_int;
        end else if (IR[15:12] == BRANCH_OPCODE) begin
            cond_sel = IR[COND_LSB+3:COND_LSB];
        end
    end

    cond_eval u_cond_eval (
        .cond (cond_sel),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    // Not every IR bit (nor FLUSH) is consumed in every build.
    logic unused_inputs;
    assign unused_inputs = ^{IR, FLUSH};

    assign FLAGS     = flags_q;
    assign COND_TRUE = cond_pass;
    assign EXEC      = IR_VALID & ~STALL & cond_pass;
    assign IT_ACTIVE = it_active;
    assign IT_COND   = it_cond_int;

endmodule

// File: tb/tb_cond_it_unit.sv
// Self-checking bench for cond_it_unit: condition-code table plus IT-block,
// stall, flush and reset sequences; expectations adapt to COND_IT_EN.
module tb_cond_it_unit;

`ifdef COND_IT_EN
    localparam bit IT = 1'b1;
`else
    localparam bit IT = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [15:0] ir;
        logic       v;
        logic       st;
        logic       fl;
        logic       we;
        logic [3:0] fin;
        logic       rst;
        logic       ct;
        logic       act;
        logic [3:0] itc;
        logic [3:0] flags;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        ir_valid;
    logic        stall;
    logic        flush;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic [3:0]  flags;
    logic        cond_true;
    logic        exec;
    logic        it_active;
    logic [3:0]  it_cond;

    int checks = 0;
    int errors = 0;
    int vec_idx = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    cond_it_unit #(
        .IR_W      (16),
        .COND_LSB  (8),
        .FLAGS_RST (4'h0)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IR        (ir),
        .IR_VALID  (ir_valid),
        .STALL     (stall),
        .FLUSH     (flush),
        .FLAG_WE   (flag_we),
        .FLAG_IN   (flag_in),
        .FLAGS     (flags),
        .COND_TRUE (cond_true),
        .EXEC      (exec),
        .IT_ACTIVE (it_active),
        .IT_COND   (it_cond)
    );

    function automatic vec_t mk(string tag, logic [15:0] i, logic v, logic st, logic fl,
                                logic we, logic [3:0] fin, logic r, logic ct, logic act,
                                logic [3:0] itc, logic [3:0] fg);
        vec_t x;
        x.tag = tag; x.ir = i; x.v = v; x.st = st; x.fl = fl; x.we = we; x.fin = fin;
        x.rst = r; x.ct = ct; x.act = act; x.itc = itc; x.flags = fg;
        return x;
    endfunction

    task automatic chk(string tag, string what, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] %s got %h want %h", tag, vec_idx, what, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, compare on the falling edge.
    task automatic apply(vec_t x);
        vec_t e;
        logic exp_exec;
        ir = x.ir; ir_valid = x.v; stall = x.st; flush = x.fl;
        flag_we = x.we; flag_in = x.fin; rst = x.rst;
        sb.push_back(x);
        @(negedge clk);
        e = sb.pop_front();
        exp_exec = e.v & ~e.st & e.ct;
        chk(e.tag, "cond_true", {3'b0, cond_true}, {3'b0, e.ct});
        chk(e.tag, "exec",      {3'b0, exec},      {3'b0, exp_exec});
        chk(e.tag, "it_active", {3'b0, it_active}, {3'b0, e.act});
        chk(e.tag, "it_cond",   it_cond,           e.itc);
        chk(e.tag, "flags",     flags,             e.flags);
        $display("vec %s[%0d] ir=%h v=%0b st=%0b fl=%0b we=%0b rst=%0b -> ct=%0b ex=%0b act=%0b itc=%h flags=%h",
                 e.tag, vec_idx, e.ir, e.v, e.st, e.fl, e.we, e.rst,
                 cond_true, exec, it_active, it_cond, flags);
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    // Shorthand for an accepted instruction with nothing else happening.
    task automatic ins(string tag, logic [15:0] i, logic ct, logic act, logic [3:0] itc,
                       logic [3:0] fg);
        apply(mk(tag, i, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, ct, act, itc, fg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ir = 16'h0; ir_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        flag_we = 1'b0; flag_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;

        // Condition-code table; flags column is the registered value that cycle.
        tbl.push_back(mk("cc", 16'h0000, 0, 0, 0, 1, 4'h4, 0, 1, 0, 4'hE, 4'h0));
        tbl.push_back(mk("cc", 16'hD800, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hD900, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hDD00, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hDC00, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hD000, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hD100, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hD000, 1, 0, 0, 1, 4'h9, 0, 1, 0, 4'hE, 4'h4));
        tbl.push_back(mk("cc", 16'hDA00, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hDB00, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hDC00, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hD400, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hD500, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hD600, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hD700, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hD200, 1, 0, 0, 1, 4'h2, 0, 0, 0, 4'hE, 4'h9));
        tbl.push_back(mk("cc", 16'hD200, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hD300, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hD800, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hD900, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hDF00, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hDE00, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'h4400, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hD300, 1, 1, 0, 0, 4'h0, 0, 0, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hDE00, 1, 1, 0, 1, 4'h0, 0, 1, 0, 4'hE, 4'h2));
        tbl.push_back(mk("cc", 16'hD000, 1, 0, 0, 1, 4'h4, 0, 0, 0, 4'hE, 4'h0));
        tbl.push_back(mk("cc", 16'hD000, 1, 0, 0, 0, 4'h0, 0, 1, 0, 4'hE, 4'h4));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // IT EQ,T,E with Z=1: slots EQ, EQ, NE then the block ends.
        ins("it3", 16'hBF06, 1, 0, 4'hE, 4'h4);
        ins("it3", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'h4);
        ins("it3", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'h4);
        ins("it3", 16'h4400, IT ? 1'b0 : 1'b1, IT, IT ? 4'h1 : 4'hE, 4'h4);
        ins("it3", 16'h4400, 1, 0, 4'hE, 4'h4);

        // Four-slot IT block with a 3-cycle stall after slot 1.
        ins("it4", 16'hBF01, 1, 0, 4'hE, 4'h4);
        ins("it4", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'h4);
        apply(mk("it4", 16'h4400, 1, 1, 0, 0, 4'h0, 0, 1, IT, IT ? 4'h0 : 4'hE, 4'h4));
        apply(mk("it4", 16'h4400, 1, 1, 0, 1, 4'hC, 0, 1, IT, IT ? 4'h0 : 4'hE, 4'h4));
        apply(mk("it4", 16'h4400, 1, 1, 0, 0, 4'h0, 0, 1, IT, IT ? 4'h0 : 4'hE, 4'hC));
        apply(mk("it4", 16'h4400, 0, 0, 0, 0, 4'h0, 0, 1, IT, IT ? 4'h0 : 4'hE, 4'hC));
        ins("it4", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'hC);
        ins("it4", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'hC);
        ins("it4", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'hC);
        ins("it4", 16'h4400, 1, 0, 4'hE, 4'hC);

        // Flush alongside the IT opcode, then flush in slot 2.
        apply(mk("flush", 16'hBF06, 1, 0, 1, 0, 4'h0, 0, 1, 0, 4'hE, 4'hC));
        ins("flush", 16'h4400, 1, 0, 4'hE, 4'hC);
        ins("flush", 16'hBF06, 1, 0, 4'hE, 4'hC);
        ins("flush", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'hC);
        apply(mk("flush", 16'h4400, 1, 0, 1, 0, 4'h0, 0, 1, IT, IT ? 4'h0 : 4'hE, 4'hC));
        ins("flush", 16'h4400, 1, 0, 4'hE, 4'hC);

        // IT opcode inside a block occupies a slot without reloading.
        ins("nest", 16'hBF06, 1, 0, 4'hE, 4'hC);
        ins("nest", 16'hBF01, 1, IT, IT ? 4'h0 : 4'hE, 4'hC);
        ins("nest", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'hC);
        ins("nest", 16'h4400, IT ? 1'b0 : 1'b1, IT, IT ? 4'h1 : 4'hE, 4'hC);
        ins("nest", 16'h4400, 1, 0, 4'hE, 4'hC);

        // Reset mid-block wins over a concurrent flag write and acceptance.
        apply(mk("rst", 16'h4400, 1, 0, 0, 1, 4'hF, 0, 1, 0, 4'hE, 4'hC));
        ins("rst", 16'hBF06, 1, 0, 4'hE, 4'hF);
        ins("rst", 16'h4400, 1, IT, IT ? 4'h0 : 4'hE, 4'hF);
        apply(mk("rst", 16'h4400, 1, 0, 0, 1, 4'hF, 1, 1, IT, IT ? 4'h0 : 4'hE, 4'hF));
        ins("rst", 16'hD000, 0, 0, 4'hE, 4'h0);
        ins("rst", 16'hBF06, 1, 0, 4'hE, 4'h0);
        ins("rst", 16'h4400, IT ? 1'b0 : 1'b1, IT, IT ? 4'h0 : 4'hE, 4'h0);
        apply(mk("rst", 16'h4400, 0, 0, 1, 0, 4'h0, 0, IT ? 1'b0 : 1'b1, IT,
                 IT ? 4'h0 : 4'hE, 4'h0));
        ins("rst", 16'h4400, 1, 0, 4'hE, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
